// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps at most one imem request outstanding and buffers one returned
// instruction while ID is stalled. EX redirects flush both the in-flight
// response and the buffered instruction.
module fetch_unit #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // instruction memory request/response
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    // redirect from EX
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    // hazard unit
    input  logic                  stall,
    // IF/ID register towards the decoder
    output logic [INST_WIDTH-1:0] if_id_inst,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic                  if_id_valid
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  discard_q, discard_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [INST_WIDTH-1:0] buf_inst_q, buf_inst_d;
    logic [ADDR_WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic [INST_WIDTH-1:0] if_id_inst_q, if_id_inst_d;
    logic [ADDR_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
    logic                  if_id_valid_q, if_id_valid_d;

    logic                  accept;
    logic                  id_free;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic                  unused_redirect_lsbs;

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = pc_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;

    assign accept  = imem_req && imem_ready;
    // ID takes a new instruction unless it is stalled on a real one.
    assign id_free = !stall || !if_id_valid_q;

    // Instructions are word aligned; the low target bits are dropped.
    assign redirect_aligned     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Next-state logic for the FSM, PC, buffer and IF/ID register.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        discard_d     = discard_q;
        buf_valid_d   = buf_valid_q;
        buf_inst_d    = buf_inst_q;
        buf_pc_d      = buf_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;

        // ID consumed whatever it held: bubble unless something new lands below.
        if (!stall) begin
            if_id_valid_d = 1'b0;
            if_id_inst_d  = NOP_INST;
        end

        case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (accept) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_WIDTH'(4);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end else if (id_free) begin
                        if_id_inst_d  = imem_rdata;
                        if_id_pc_d    = req_pc_q;
                        if_id_valid_d = 1'b1;
                        state_d       = StReq;
                    end else begin
                        buf_inst_d  = imem_rdata;
                        buf_pc_d    = req_pc_q;
                        buf_valid_d = 1'b1;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                if (!stall) begin
                    if_id_inst_d  = buf_inst_q;
                    if_id_pc_d    = buf_pc_q;
                    if_id_valid_d = 1'b1;
                    buf_valid_d   = 1'b0;
                    state_d       = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Redirect wins over everything, including stall.
        if (redirect_valid) begin
            pc_d          = redirect_aligned;
            if_id_valid_d = 1'b0;
            if_id_inst_d  = NOP_INST;
            buf_valid_d   = 1'b0;
            case (state_q)
                StReq: begin
                    if (accept) begin
                        // The stale address went out; its response must be dropped.
                        state_d   = StWait;
                        discard_d = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        state_d   = StReq;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = StWait;
                        discard_d = 1'b1;
                    end
                end
                default: begin
                    state_d = StReq;
                end
            endcase
        end
    end

    // State, PC and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            discard_q     <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_inst_q    <= NOP_INST;
            buf_pc_q      <= '0;
            if_id_inst_q  <= NOP_INST;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            discard_q     <= discard_d;
            buf_valid_q   <= buf_valid_d;
            buf_inst_q    <= buf_inst_d;
            buf_pc_q      <= buf_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the ID-stage decoder.
- Generates the PC and issues single-outstanding requests to instruction memory.
- Buffers one returned instruction under ID stall, and presents a registered instruction, PC and valid to ID.
- Accepts branch/jump redirects from EX, which flush in-flight and buffered fetches.

Parameters:
- INST_WIDTH, 32: instruction width.
- ADDR_WIDTH, 32: PC / imem address width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INST, 32'h0000_0013: bubble instruction (addi x0,x0,0) driven when IF/ID is invalid.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  request valid; high only in state REQ.
- imem_addr  out  ADDR_WIDTH  request address, equals pc_q.
- imem_ready  in  1  imem accepts the request this cycle when imem_req&&imem_ready.
- imem_rvalid  in  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rdata  in  INST_WIDTH  response instruction.
- redirect_valid  in  1  EX redirect (taken branch/jump).
- redirect_pc  in  ADDR_WIDTH  redirect target.
- stall  in  1  hazard unit: ID cannot consume; hold IF/ID.
- if_id_inst  out  INST_WIDTH  instruction to decoder.
- if_id_pc  out  ADDR_WIDTH  PC of if_id_inst.
- if_id_valid  out  1  if_id_inst is a real instruction.

Behaviour:
- Reset (async on rst_n=0):
  - state=IDLE, pc_q=RESET_PC, req_pc_q=0, discard_q=0, buf_valid=0.
  - if_id_inst=NOP_INST, if_id_pc=0, if_id_valid=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC.
- FSM states IDLE, REQ, WAIT, HOLD:
  - IDLE: imem_req=0. Goes to REQ on the next cycle.
  - REQ: imem_req=1. If imem_ready: req_pc_q<=pc_q, pc_q<=pc_q+4 (wraps modulo 2^ADDR_WIDTH), go to WAIT. Otherwise stay in REQ with the address held stable.
  - WAIT: imem_req=0. On imem_rvalid:
    - discard_q=1: drop the response, clear discard_q, go to REQ.
    - else, if ID can accept (!stall || !if_id_valid): load if_id_inst<=imem_rdata, if_id_pc<=req_pc_q, if_id_valid<=1, go to REQ.
    - else: capture into the buffer (buf_inst, buf_pc, buf_valid=1) and go to HOLD.
  - HOLD: imem_req=0. When !stall, move the buffer into IF/ID (valid=1), clear buf_valid, go to REQ.
- IF/ID hold and bubble:
  - When stall && if_id_valid, the IF/ID registers are held.
  - When !stall and no new instruction arrives this cycle: if_id_valid<=0, if_id_inst<=NOP_INST, if_id_pc is don't-care (held).
- Redirect (highest priority; overrides stall):
  - pc_q<=redirect_pc with bits [1:0] forced to 0.
  - if_id_valid<=0, if_id_inst<=NOP_INST, buf_valid<=0.
  - Next state, by current state:
    - REQ, request accepted this cycle: WAIT with discard_q<=1, because the stale address was accepted.
    - REQ, not accepted: stay in REQ.
    - WAIT without rvalid: stay in WAIT, discard_q<=1.
    - WAIT with rvalid: drop the response, go to REQ, discard_q<=0.
    - HOLD: REQ.
    - IDLE: REQ.
  - The next REQ issues redirect_pc.
- Other rules:
  - At most one outstanding request at any time. Peak throughput is one instruction per 2 cycles with 1-cycle imem latency.
  - rvalid outside WAIT is a protocol violation; the block ignores it, and a bench assertion flags it.
  - if_id_valid never rises in the cycle after a redirect.
  - An instruction fetched from a pre-redirect address never reaches IF/ID.

Test Plan:
1. Reset then straight-line fetch, 1-cycle memory with imem_ready=1 → imem_addr sequence 0,4,8. IF/ID shows (pc 0, inst A), (4,B), (8,C) with valid=1 every other cycle and NOP bubbles between.
2. Backpressure: imem_ready=0 for 3 cycles at pc 8 → imem_req held high, imem_addr=8 stable. pc_q advances to 12 only on the cycle imem_ready=1.
3. Stall with buffering: IF/ID holds pc 4; stall=1 for 4 cycles while pc 8 returns → state HOLD and IF/ID unchanged. One cycle after stall drops, IF/ID=(8,C), then the fetch at 12 issues.
4. Redirect during WAIT: request pc 8 outstanding, redirect_valid with redirect_pc=0x100 → response for pc 8 discarded and IF/ID invalid. The next request addresses 0x100 and IF/ID later shows pc 0x100.
5. Redirect coincident with stall and a full buffer (HOLD) → buffer and IF/ID cleared (valid=0). The next imem_addr is redirect_pc, and redirect_pc=0x103 is issued as 0x100.
6. Async reset mid-WAIT: rst_n low between clock edges → all outputs take their reset values immediately. After release, the first request is RESET_PC after one IDLE cycle, and a late stale rvalid is ignored.
